clk_counter_leds_top: RTL and testbench

CLK_COUNTER_LEDS_TOP -- requirements
Module: clk_counter_leds_top

---
 rtl/clk_counter_leds_top.sv | 66 ++++++
 tb/tb_clk_counter_leds_top.sv | 139 +++++++++++++
 2 files changed

// File: rtl/clk_counter_leds_top.sv
// LED binary counter stepped by a prescaler at EXT_CLOCK_FREQ/5 (0.2 s per step at the default clock).
// Optional overflow indicator on the LED MSB, enabled by defining OVERFLOW_LED_EN.
module clk_counter_leds_top #(
    parameter int  EXT_CLOCK_FREQ   = 50000000,
    parameter real EXT_CLOCK_PERIOD = 20.000,
    parameter int  LEDG_SIZE        = 8
) (
    input  logic                 EXTCLK,
    input  logic [1:0]           KEY,
    output logic [LEDG_SIZE-1:0] LEDG
);

    localparam int COUNT_FREQ   = EXT_CLOCK_FREQ / 5;
    localparam int COUNT_WIDTH  = ($clog2(COUNT_FREQ) < 1) ? 1 : $clog2(COUNT_FREQ);
    localparam int LED_WIDTH    = LEDG_SIZE - 1;
    localparam logic [COUNT_WIDTH-1:0] TERMINAL = COUNT_WIDTH'(COUNT_FREQ - 1);

    logic [COUNT_WIDTH-1:0] r_clk_counter;
    logic [LED_WIDTH-1:0]   r_led_counter;
    logic [COUNT_WIDTH-1:0] w_clk_counter_next;
    logic [LED_WIDTH-1:0]   w_led_counter_next;
    logic                   w_enable;
    logic                   w_step;

    assign w_enable = ~KEY[1];
    assign w_step   = w_enable && (r_clk_counter == TERMINAL);

    // A disabled cycle restarts the prescaler so re-enabling always costs a full period.
    always_comb begin
        w_clk_counter_next = '0;
        w_led_counter_next = r_led_counter;
        if (w_enable && !w_step) begin
            w_clk_counter_next = r_clk_counter + 1'b1;
        end
        if (w_step) begin
            w_led_counter_next = r_led_counter + 1'b1;
        end
    end

    always_ff @(posedge EXTCLK or negedge KEY[0]) begin
        if (!KEY[0]) begin
            r_clk_counter <= '0;
            r_led_counter <= '0;
        end else begin
            r_clk_counter <= w_clk_counter_next;
            r_led_counter <= w_led_counter_next;
        end
    end

`ifdef OVERFLOW_LED_EN
    logic r_overflow;

    always_ff @(posedge EXTCLK or negedge KEY[0]) begin
        if (!KEY[0]) begin
            r_overflow <= 1'b0;
        end else if (w_step) begin
            r_overflow <= &r_led_counter;
        end
    end

    assign LEDG = {r_overflow, r_led_counter};
`else
    assign LEDG = {1'b0, r_led_counter};
`endif

endmodule

// File: tb/tb_clk_counter_leds_top.sv
// Randomized self-checking bench for clk_counter_leds_top using a step-count reference model.
// Runs with a scaled clock frequency so COUNT_FREQ = 10.
module tb_clk_counter_leds_top;

    localparam int FREQ = 50;
    localparam int CF   = FREQ / 5;

    logic       EXTCLK;
    logic [1:0] KEY;
    logic [7:0] LEDG;

    int checks;
    int errors;
    int m_phase;
    int m_steps;

    clk_counter_leds_top #(
        .EXT_CLOCK_FREQ  (FREQ),
        .EXT_CLOCK_PERIOD(10.0),
        .LEDG_SIZE       (8)
    ) dut (
        .EXTCLK(EXTCLK),
        .KEY   (KEY),
        .LEDG  (LEDG)
    );

    initial EXTCLK = 1'b0;
    always #5 EXTCLK = ~EXTCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_ledg();
        logic [6:0] led;
        logic       ovf;
        led = 7'(m_steps % 128);
`ifdef OVERFLOW_LED_EN
        ovf = (m_steps > 0) && (led == 7'd0);
`else
        ovf = 1'b0;
`endif
        return {ovf, led};
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, "_ledg"}, {24'd0, LEDG}, {24'd0, model_ledg()});
        check_eq({tag, "_presc"}, 32'(dut.r_clk_counter), 32'(m_phase));
        check_eq({tag, "_ovf_only_at_zero"}, 32'(LEDG[7] && (LEDG[6:0] != 7'd0)), 32'd0);
    endtask

    // Called at a falling edge; drives KEY, advances one rising edge, checks after it.
    task automatic cycle(input logic k0, input logic k1, input string tag);
        KEY = {k1, k0};
        if (!k0) begin
            m_phase = 0;
            m_steps = 0;
            #1;
            check_eq({tag, "_async_rst"}, {24'd0, LEDG}, 32'd0);
        end
        @(posedge EXTCLK);
        if (k0) begin
            if (!k1) begin
                m_phase++;
                if (m_phase == CF) begin
                    m_phase = 0;
                    m_steps++;
                end
            end else begin
                m_phase = 0;
            end
        end
        #1;
        check_all(tag);
        @(negedge EXTCLK);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_phase = 0;
        m_steps = 0;
        KEY     = 2'b10;
        @(negedge EXTCLK);
        check_eq("por_ledg", {24'd0, LEDG}, 32'd0);

        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, "idle");
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, "rst_hold");
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, "rst_rel");

        for (int i = 0; i < CF - 1; i++) cycle(1'b1, 1'b0, "first_step_pre");
        cycle(1'b1, 1'b0, "first_step");
        check_eq("first_step_val", {24'd0, LEDG}, 32'h01);

        for (int i = 0; i < 2 * CF; i++) cycle(1'b1, 1'b1, "disabled");
        check_eq("disabled_val", {24'd0, LEDG}, 32'h01);

        for (int i = 0; i < 127 * CF; i++) cycle(1'b1, 1'b0, "to_wrap");
`ifdef OVERFLOW_LED_EN
        check_eq("wrap_val", {24'd0, LEDG}, 32'h80);
`else
        check_eq("wrap_val", {24'd0, LEDG}, 32'h00);
`endif
        for (int i = 0; i < CF; i++) cycle(1'b1, 1'b0, "post_wrap");
        check_eq("post_wrap_val", {24'd0, LEDG}, 32'h01);

        // Terminal-count edge with enable dropped must not step.
        for (int i = 0; i < CF - 1; i++) cycle(1'b1, 1'b0, "tc_pre");
        cycle(1'b1, 1'b1, "tc_disabled");
        check_eq("tc_suppressed", {24'd0, LEDG}, 32'h01);
        for (int i = 0; i < CF; i++) cycle(1'b1, 1'b0, "tc_restart");
        check_eq("tc_restart_val", {24'd0, LEDG}, 32'h02);

        for (int i = 0; i < 40 * CF; i++) cycle(1'b1, 1'b0, "to_2a");
        check_eq("at_2a", {24'd0, LEDG}, 32'h2A);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "mid_count");
        cycle(1'b0, 1'b0, "mid_rst");
        for (int i = 0; i < CF - 1; i++) cycle(1'b1, 1'b0, "after_rst_pre");
        check_eq("after_rst_hold", {24'd0, LEDG}, 32'h00);
        cycle(1'b1, 1'b0, "after_rst_step");
        check_eq("after_rst_val", {24'd0, LEDG}, 32'h01);

        for (int i = 0; i < 4000; i++) begin
            logic k0;
            logic k1;
            k0 = ($urandom_range(0, 199) != 0);
            k1 = ($urandom_range(0, 9) == 0);
            cycle(k0, k1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
